prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Parametrised program sequencer: next-generation fetch/control front end for the 9-bit-instruction core.
- Owns the program counter, the run/done handshake, and a writable branch-target LUT.
- Holds registered zero/equal/carry flags and resolves conditional branches.
- Drives prog_ctr to instruction ROM; receives decoded branch/halt strobes from the control decoder and raw flags from the ALU.

Parameters:
- D, 10, program counter width.
- L, 3, branch-LUT index width (2**L entries, each D bits).
- START_ADDR, 0, PC value loaded on reset and on each new run.
- END_ADDR, 2**D-1, PC value that ends a run.
- REL, 1, 1 = LUT entry is a signed PC-relative offset; 0 = absolute target.
- SD, 4, call-stack depth (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  run request (four-phase handshake).
- done  out  1  run complete.
- prog_ctr  out  D  instruction address to ROM.
- stall  in  1  hold PC this cycle.
- halt  in  1  decoded halt instruction.
- branch  in  1  decoded branch instruction.
- br_cond  in  2  condition: 0 always, 1 zeroQ, 2 equalQ, 3 !equalQ.
- lut_idx  in  L  branch-LUT read index.
- flag_en  in  1  capture flags this cycle.
- zero_i, equal_i, sc_i  in  1 each  raw ALU flags.
- zeroQ, equalQ, scQ  out  1 each  registered flags.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  L  LUT write index.
- lut_wdata  in  D  LUT write data.
- call, ret  in  1 each  subroutine strobes (used only with the optional feature).
- stk_err  out  1  sticky stack error.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, prog_ctr=START_ADDR, done=0, all flags=0, all LUT entries=0, stack empty, stk_err=0.
- IDLE:
  - prog_ctr held at START_ADDR; done=0.
  - req=1 at a clock edge moves to RUN; the first fetch is at START_ADDR in the cycle after.
- RUN, priority highest first, evaluated each clock edge:
  1. stall=1: everything holds.
  2. halt=1, or prog_ctr==END_ADDR: go to DONE; PC holds.
  3. Branch taken (branch=1 and condition true, using registered flags): next PC = prog_ctr + sign-extended LUT[lut_idx] (REL=1, modulo 2**D) or LUT[lut_idx] (REL=0).
  4. Otherwise: prog_ctr+1, wrapping modulo 2**D.
- DONE:
  - done=1 and PC holds.
  - req=0 at a clock edge moves to IDLE: done=0, prog_ctr=START_ADDR.
  - req held high keeps the block in DONE; there is no automatic restart.
- Flags:
  - Flags load on flag_en=1, regardless of state and stall.
  - A branch in the same cycle sees the old flags (one-cycle flag latency).
- LUT:
  - Synchronous write, writable in any state.
  - A same-cycle write and read of one index returns the old value.
- Deassertion of req during RUN is ignored; the run completes.
- Reset during RUN or DONE aborts immediately to the IDLE reset values.
- Latency: req to first fetch is 1 cycle; halt to done is 1 cycle.

Optional Feature:
- Macro CALL_STACK_EN.
- When defined:
  - An SD-deep return stack exists.
  - call=1 (RUN, not stalled) pushes prog_ctr+1 and jumps to the LUT target as in an always-taken branch.
  - ret=1 pops into prog_ctr.
  - Priority: halt > ret > call > branch.
  - Push when full: push ignored, jump still taken, stk_err=1.
  - Pop when empty: PC+1, stk_err=1.
  - stk_err is sticky until reset or the IDLE-to-RUN transition.
- When undefined: call and ret are ignored, no stack storage exists, stk_err is tied to 0.

Decomposition:
- Package seq_pkg holds:
  - typedef enum state_t {IDLE, RUN, DONE};
  - br_cond encodings as localparams;
  - a function for the sign-extended relative add.
- One sub-module is natural: branch_lut, a 2**L x D register array with one write port and one async read port.
- The stack is inline in the sequencer.

Test Plan:
- Reset, then req=1: prog_ctr=START_ADDR (0) in IDLE; after 1 cycle of req, prog_ctr counts 0,1,2,3; done=0.
- LUT[2]=-3 (REL=1), PC=10, branch=1, br_cond=0, lut_idx=2: next prog_ctr=7; with br_cond=2 and equalQ=0, next prog_ctr=11.
- flag_en=1 with zero_i=1 in the same cycle as branch with br_cond=1: branch not taken (old zeroQ=0); an identical branch in the next cycle is taken.
- Run to END_ADDR=20: done=1 one cycle after PC=20; req held high keeps done=1; req=0 gives done=0 and prog_ctr=0 next cycle.
- reset pulled low mid-RUN at PC=5 with stall=1: immediate async clear to prog_ctr=0, flags 0, state IDLE.
- CALL_STACK_EN, SD=2: three nested calls set stk_err=1 with only two return addresses stored; two rets then return correctly; a third ret gives PC+1 and stk_err stays 1.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the program sequencer and its branch LUT.
package seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0] BR_ALWAYS = 2'd0;
  localparam logic [1:0] BR_ZERO   = 2'd1;
  localparam logic [1:0] BR_EQ     = 2'd2;
  localparam logic [1:0] BR_NEQ    = 2'd3;

  // Sign-extends the w-bit offset before adding. The caller truncates the sum to its PC width.
  function automatic logic [31:0] rel_add(input logic [31:0] pc, input logic [31:0] off,
                                          input int w);
    logic [31:0] sx;
    sx = 32'($signed(off << (32 - w)) >>> (32 - w));
    return pc + sx;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: 2**L x D registers, one synchronous write port, one async read port.
module branch_lut #(
  parameter int D = 10,
  parameter int L = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [L-1:0] waddr,
  input  logic [D-1:0] wdata,
  input  logic [L-1:0] raddr,
  output logic [D-1:0] rdata
);
  localparam int N = 2**L;

  logic [N-1:0][D-1:0] mem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mem_q <= '0;
    else if (we) mem_q[waddr] <= wdata;
  end

  // Reads return the stored value, so a same-cycle write is not visible until the next cycle.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: PC, run/done handshake, flags and branch resolution.
// Build with CALL_STACK_EN defined to add the SD-deep call/return stack.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int           D          = 10,
  parameter int           L          = 3,
  parameter logic [D-1:0] START_ADDR = '0,
  parameter logic [D-1:0] END_ADDR   = '1,
  parameter bit           REL        = 1'b1,
  parameter int           SD         = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  output logic         done,
  output logic [D-1:0] prog_ctr,
  input  logic         stall,
  input  logic         halt,
  input  logic         branch,
  input  logic [1:0]   br_cond,
  input  logic [L-1:0] lut_idx,
  input  logic         flag_en,
  input  logic         zero_i,
  input  logic         equal_i,
  input  logic         sc_i,
  output logic         zeroQ,
  output logic         equalQ,
  output logic         scQ,
  input  logic         lut_we,
  input  logic [L-1:0] lut_waddr,
  input  logic [D-1:0] lut_wdata,
  input  logic         call,
  input  logic         ret,
  output logic         stk_err
);
  state_t       state_q, state_d;
  logic [D-1:0] pc_q, pc_d, pc_inc, lut_rd, br_tgt;
  logic         zero_q, equal_q, sc_q, cond_ok;

  branch_lut #(.D(D), .L(L)) u_lut (
    .clk(clk), .reset(reset), .we(lut_we), .waddr(lut_waddr), .wdata(lut_wdata),
    .raddr(lut_idx), .rdata(lut_rd)
  );

  assign pc_inc = pc_q + D'(1);
  assign br_tgt = REL ? D'(rel_add(32'(pc_q), 32'(lut_rd), D)) : lut_rd;

  always_comb begin
    case (br_cond)
      BR_ZERO: cond_ok = zero_q;
      BR_EQ:   cond_ok = equal_q;
      BR_NEQ:  cond_ok = !equal_q;
      default: cond_ok = 1'b1;
    endcase
  end

`ifdef CALL_STACK_EN
  localparam int SPW = $clog2(SD + 1);
  logic [SD-1:0][D-1:0] stk_q, stk_d;
  logic [SPW-1:0]       sp_q, sp_d;
  logic                 stk_err_q, stk_err_d;
  assign stk_err = stk_err_q;
`else
  logic unused_stk;
  assign unused_stk = call ^ ret;
  assign stk_err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef CALL_STACK_EN
    stk_d     = stk_q;
    sp_d      = sp_q;
    stk_err_d = stk_err_q;
`endif
    case (state_q)
      IDLE: begin
        pc_d = START_ADDR;
        if (req) begin
          state_d = RUN;
`ifdef CALL_STACK_EN
          // Each run starts with a clean stack and error state.
          sp_d      = '0;
          stk_err_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (!stall) begin
          if (halt || pc_q == END_ADDR) state_d = DONE;
`ifdef CALL_STACK_EN
          else if (ret) begin
            if (sp_q == '0) begin
              pc_d      = pc_inc;
              stk_err_d = 1'b1;
            end else begin
              sp_d = sp_q - SPW'(1);
              for (int i = 0; i < SD; i++)
                if (SPW'(i) == sp_q - SPW'(1)) pc_d = stk_q[i];
            end
          end else if (call) begin
            pc_d = br_tgt;
            if (sp_q == SPW'(SD)) stk_err_d = 1'b1;
            else begin
              sp_d = sp_q + SPW'(1);
              for (int i = 0; i < SD; i++)
                if (SPW'(i) == sp_q) stk_d[i] = pc_inc;
            end
          end
`endif
          else if (branch && cond_ok) pc_d = br_tgt;
          else pc_d = pc_inc;
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
          pc_d    = START_ADDR;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= START_ADDR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Flags capture independently of state and stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_q  <= 1'b0;
      equal_q <= 1'b0;
      sc_q    <= 1'b0;
    end else if (flag_en) begin
      zero_q  <= zero_i;
      equal_q <= equal_i;
      sc_q    <= sc_i;
    end
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stk_q     <= '0;
      sp_q      <= '0;
      stk_err_q <= 1'b0;
    end else begin
      stk_q     <= stk_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
    end
  end
`endif

  assign prog_ctr = pc_q;
  assign done     = (state_q == DONE);
  assign zeroQ    = zero_q;
  assign equalQ   = equal_q;
  assign scQ      = sc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer (END_ADDR=20, SD=2); stack checks follow CALL_STACK_EN.
module tb_prog_sequencer;
  localparam int D = 10;
  localparam int L = 3;

  logic         clk, reset, req, done, stall, halt, branch, flag_en;
  logic         zero_i, equal_i, sc_i, zeroQ, equalQ, scQ;
  logic         lut_we, call, ret, stk_err;
  logic [1:0]   br_cond;
  logic [L-1:0] lut_idx, lut_waddr;
  logic [D-1:0] lut_wdata, prog_ctr;

  int total = 0;
  int bad   = 0;

  prog_sequencer #(.D(D), .L(L), .END_ADDR(10'd20), .SD(2)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .prog_ctr(prog_ctr),
    .stall(stall), .halt(halt), .branch(branch), .br_cond(br_cond), .lut_idx(lut_idx),
    .flag_en(flag_en), .zero_i(zero_i), .equal_i(equal_i), .sc_i(sc_i),
    .zeroQ(zeroQ), .equalQ(equalQ), .scQ(scQ),
    .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .call(call), .ret(ret), .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; stall = 1'b0; halt = 1'b0; branch = 1'b0; br_cond = 2'd0;
    lut_idx = '0; flag_en = 1'b0; zero_i = 1'b0; equal_i = 1'b0; sc_i = 1'b0;
    lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0; call = 1'b0; ret = 1'b0;
    #3;
    chk("rst_pc", prog_ctr, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {zeroQ, equalQ, scQ}, 0);
    chk("rst_err", stk_err, 0);
    #9 reset = 1'b1;
    tick();
    chk("idle_pc", prog_ctr, 0);

    lut_we = 1'b1; lut_waddr = 3'd2; lut_wdata = 10'h3FD;  // -3
    tick();
    lut_we = 1'b0;
    chk("idle_hold", prog_ctr, 0);

    req = 1'b1;
    tick(); chk("run_pc0", prog_ctr, 0);
    req = 1'b0;  // ignored while running
    tick(); chk("run_pc1", prog_ctr, 1);
    tick(); chk("run_pc2", prog_ctr, 2);
    tick(); chk("run_pc3", prog_ctr, 3);
    chk("run_done", done, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("run_pc10", prog_ctr, 10);

    branch = 1'b1; br_cond = 2'd0; lut_idx = 3'd2;
    tick(); chk("br_always", prog_ctr, 7);
    br_cond = 2'd2;
    tick(); chk("br_eq_nt", prog_ctr, 8);

    br_cond = 2'd1; flag_en = 1'b1; zero_i = 1'b1;
    tick(); chk("br_zero_old", prog_ctr, 9);
    chk("zeroQ_set", zeroQ, 1);
    flag_en = 1'b0; zero_i = 1'b0;
    tick(); chk("br_zero_new", prog_ctr, 6);

    br_cond = 2'd3; flag_en = 1'b1; equal_i = 1'b1; sc_i = 1'b1;
    tick(); chk("br_neq_old", prog_ctr, 3);
    chk("flags_new", {zeroQ, equalQ, scQ}, 3'b011);
    flag_en = 1'b0; equal_i = 1'b0; sc_i = 1'b0;
    tick(); chk("br_neq_nt", prog_ctr, 4);
    branch = 1'b0;

    stall = 1'b1;
    tick(); chk("stall_hold", prog_ctr, 4);
    stall = 1'b0;

    branch = 1'b1; br_cond = 2'd0; lut_we = 1'b1; lut_waddr = 3'd2; lut_wdata = 10'd5;
    tick(); chk("lut_rw_old", prog_ctr, 1);
    lut_we = 1'b0;
    tick(); chk("lut_new", prog_ctr, 6);
    branch = 1'b0;

`ifdef CALL_STACK_EN
    call = 1'b1;
    tick(); chk("call1", prog_ctr, 11);
    tick(); chk("call2", prog_ctr, 16);
    chk("call2_err", stk_err, 0);
    tick(); chk("call3", prog_ctr, 21);
    chk("call3_err", stk_err, 1);
    call = 1'b0; ret = 1'b1;
    tick(); chk("ret1", prog_ctr, 12);
    tick(); chk("ret2", prog_ctr, 7);
    tick(); chk("ret3", prog_ctr, 8);
    chk("ret3_err", stk_err, 1);
    ret = 1'b0;
`else
    call = 1'b1;
    tick(); chk("call_ign", prog_ctr, 7);
    call = 1'b0; ret = 1'b1;
    tick(); chk("ret_ign", prog_ctr, 8);
    chk("err_tied", stk_err, 0);
    ret = 1'b0;
`endif

    for (int i = 0; i < 12; i++) tick();
    chk("end_pc", prog_ctr, 20);
    chk("end_nodone", done, 0);
    req = 1'b1;
    tick(); chk("done_set", done, 1);
    chk("done_pc", prog_ctr, 20);
    tick(); chk("done_hold", done, 1);
    req = 1'b0;
    tick(); chk("done_clr", done, 0);
    chk("idle_pc0", prog_ctr, 0);
    tick(); chk("idle_stay", prog_ctr, 0);

    req = 1'b1;
    tick(); chk("rerun_pc", prog_ctr, 0);
    chk("rerun_err", stk_err, 0);
    tick(); chk("rerun_pc1", prog_ctr, 1);
    halt = 1'b1;
    tick(); chk("halt_done", done, 1);
    chk("halt_pc", prog_ctr, 1);
    halt = 1'b0; req = 1'b0;
    tick(); chk("halt_idle", done, 0);

    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_pc5", prog_ctr, 5);
    stall = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_pc", prog_ctr, 0);
    chk("arst_flags", {zeroQ, equalQ, scQ}, 0);
    chk("arst_done", done, 0);
    #2 reset = 1'b1;
    stall = 1'b0;
    tick(); chk("arst_idle", prog_ctr, 0);
    req = 1'b1;
    tick();
    req = 1'b0; branch = 1'b1; br_cond = 2'd0; lut_idx = 3'd2;
    tick(); chk("arst_lut", prog_ctr, 0);
    branch = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
